// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse macro emulator: FSM state encoding,
// sticky error flag bit positions, and the default fuse array size.
// No ports; imported by efuse_emulator.
package efuse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PROG    = 2'd2,
    WAIT_CS = 2'd3
  } efuse_state_t;

  // Bit positions inside the sticky err[2:0] vector.
  localparam int ERR_OVR   = 0;  // SCLK rise with the slot index already at NBITS
  localparam int ERR_SHORT = 1;  // PGM pulse too short, cut off by CS, or locked out
  localparam int ERR_RW    = 2;  // RW moved while CS was high

  localparam int NBITS_DEF = 32;

endpackage

// File: rtl/efuse_pin_sync.sv
// Purpose: multi-flop synchronizer plus rise/fall detect for one slow interface pin.
// Latency: level follows the pin after SYNC_STAGES clk; rise/fall are one-clk pulses aligned to that level.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (async, active-high), pin (async input),
//        level (synchronized copy), rise / fall (single-cycle edge strobes).
module efuse_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/efuse_emulator.sv
// Purpose: macro-side responder for the EFUSE SCLK/CS/RW/PGM/DOUT serial interface, holding an OTP fuse array.
// Latency: DOUT reflects a pin edge SYNC_STAGES+1 clk later; burns land one clk after the synchronized PGM fall.
// Backpressure: none; the controller paces frames through SCLK/CS and must keep SCLK period >= 400 ns.
// Ports: clk, rst (async, active-high); EFUSE_SCLK/CS/RW/PGM pins in; EFUSE_DOUT serial read data out;
//        fuse_q array contents; frame_done one-clk pulse on a valid frame close; burn_cnt saturating
//        count of 0->1 burns; err sticky {rw_change, short_pgm, overrun}; err_clr synchronous clear.
// Optional: define EFUSE_EMU_LOCK_EN to make fuse_q[NBITS-1] a lock bit that blocks later burns.
module efuse_emulator
  import efuse_pkg::*;
#(
  parameter int               NBITS       = NBITS_DEF,
  parameter int               PGM_MIN_CYC = 4,
  parameter int               SYNC_STAGES = 2,
  parameter logic [NBITS-1:0] INIT_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EFUSE_SCLK,
  input  logic             EFUSE_CS,
  input  logic             EFUSE_RW,
  input  logic             EFUSE_PGM,
  output logic             EFUSE_DOUT,
  output logic [NBITS-1:0] fuse_q,
  output logic             frame_done,
  output logic [7:0]       burn_cnt,
  output logic [2:0]       err,
  input  logic             err_clr
);

  // idx must be able to hold NBITS itself (the saturated "past the end" slot).
  localparam int               IW       = $clog2(NBITS + 1);
  localparam int               CW       = $clog2(PGM_MIN_CYC + 1);
  localparam logic [IW-1:0]    IDX_MAX  = IW'(NBITS);
  localparam logic [CW-1:0]    CNT_MIN  = CW'(PGM_MIN_CYC);
  localparam logic [NBITS-1:0] ONE_HOT0 = {{(NBITS-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic rw_lvl, rw_rise, rw_fall;
  logic pgm_lvl, pgm_rise, pgm_fall;

  efuse_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(EFUSE_SCLK), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  efuse_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .pin(EFUSE_CS), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  efuse_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rw (
    .clk(clk), .rst(rst), .pin(EFUSE_RW), .level(rw_lvl), .rise(rw_rise), .fall(rw_fall)
  );
  efuse_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pgm (
    .clk(clk), .rst(rst), .pin(EFUSE_PGM), .level(pgm_lvl), .rise(pgm_rise), .fall(pgm_fall)
  );

  // Edge/level outputs this block has no use for; RW changes are caught by
  // comparing the level against the value latched at CS rise.
  logic unused_pins;
  assign unused_pins = ^{sclk_lvl, sclk_fall, rw_rise, rw_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  efuse_state_t     state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [CW-1:0]    pgm_cnt, pgm_cnt_n;
  logic             rw_q, rw_n;
  logic             dout_n;
  logic [NBITS-1:0] fuse_n;
  logic [7:0]       burn_cnt_n;
  logic             frame_done_n;
  logic [2:0]       err_set, err_n;
  logic [NBITS-1:0] rd_sh;
  logic [NBITS-1:0] burn_mask;
  logic             burn_locked;

`ifdef EFUSE_EMU_LOCK_EN
  // Lock bit value captured at the start of each program frame, so the frame
  // that burns the lock bit can still complete its other burns.
  logic lock_q, lock_n;
  assign burn_locked = lock_q;
`else
  assign burn_locked = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pgm_cnt    <= '0;
      rw_q       <= 1'b0;
      EFUSE_DOUT <= 1'b0;
      fuse_q     <= INIT_VAL;
      burn_cnt   <= 8'd0;
      frame_done <= 1'b0;
      err        <= 3'b000;
`ifdef EFUSE_EMU_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      pgm_cnt    <= pgm_cnt_n;
      rw_q       <= rw_n;
      EFUSE_DOUT <= dout_n;
      fuse_q     <= fuse_n;
      burn_cnt   <= burn_cnt_n;
      frame_done <= frame_done_n;
      err        <= err_n;
`ifdef EFUSE_EMU_LOCK_EN
      lock_q     <= lock_n;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    pgm_cnt_n    = pgm_cnt;
    rw_n         = rw_q;
    dout_n       = 1'b0;
    fuse_n       = fuse_q;
    burn_cnt_n   = burn_cnt;
    frame_done_n = 1'b0;
    err_set      = 3'b000;
    rd_sh        = '0;
    burn_mask    = ONE_HOT0 << idx;
`ifdef EFUSE_EMU_LOCK_EN
    lock_n       = lock_q;
`endif

    case (state)
      IDLE: begin
        if (cs_rise) begin
          rw_n      = rw_lvl;
          idx_n     = '0;
          pgm_cnt_n = '0;
`ifdef EFUSE_EMU_LOCK_EN
          lock_n    = fuse_q[NBITS-1];
`endif
          if (rw_lvl) begin
            state_n = PROG;
          end else begin
            state_n = READ;
            dout_n  = fuse_q[0];
          end
        end
      end

      READ: begin
        dout_n = EFUSE_DOUT;
        if (cs_fall) begin
          state_n      = IDLE;
          frame_done_n = 1'b1;
          dout_n       = 1'b0;
        end else if (rw_lvl != rw_q) begin
          state_n          = WAIT_CS;
          err_set[ERR_RW]  = 1'b1;
          dout_n           = 1'b0;
        end else if (sclk_rise) begin
          // The last real bit is shifted out by the NBITS-th rise moving idx to
          // NBITS; only a rise beyond that counts as an overrun.
          if (idx == IDX_MAX) err_set[ERR_OVR] = 1'b1;
          else                idx_n = idx + 1'b1;
          // Shifting past the top of the array yields 0 for idx_n == NBITS.
          rd_sh  = fuse_q >> idx_n;
          dout_n = rd_sh[0];
        end
      end

      PROG: begin
        // cs_lvl is low on a CS fall, so a close always wins over RW checking.
        if (cs_lvl && (rw_lvl != rw_q)) begin
          state_n         = WAIT_CS;
          err_set[ERR_RW] = 1'b1;
        end else begin
          // High-time counter includes the rise cycle, so a pulse of exactly
          // PGM_MIN_CYC synchronized cycles qualifies; it saturates at the limit.
          if (pgm_rise)                           pgm_cnt_n = CW'(1);
          else if (pgm_lvl && pgm_cnt < CNT_MIN)  pgm_cnt_n = pgm_cnt + 1'b1;

          // Burn uses the pre-increment idx even if SCLK rises in the same cycle.
          if (pgm_fall) begin
            if (pgm_cnt < CNT_MIN || burn_locked) begin
              err_set[ERR_SHORT] = 1'b1;
            end else if (idx < IDX_MAX && (fuse_q & burn_mask) == '0) begin
              fuse_n = fuse_q | burn_mask;
              if (burn_cnt != 8'hFF) burn_cnt_n = burn_cnt + 8'd1;
            end
          end

          if (sclk_rise) begin
            if (idx == IDX_MAX) err_set[ERR_OVR] = 1'b1;
            else                idx_n = idx + 1'b1;
          end

          if (cs_fall) begin
            state_n      = IDLE;
            frame_done_n = 1'b1;
            // A pulse still high when the frame closes is abandoned unburned.
            if (pgm_lvl) err_set[ERR_SHORT] = 1'b1;
          end
        end
      end

      WAIT_CS: begin
        // Corrupted frame: wait out CS, no frame_done.
        if (!cs_lvl) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase

    // Clear takes precedence; a flag raised in the same cycle is dropped.
    err_n = err_clr ? 3'b000 : (err | err_set);
  end

endmodule

// File: tb/tb_efuse_emulator.sv
// Purpose: directed self-checking bench for efuse_emulator acting as a simple efuse controller.
// Latency: pins are driven 1 ns after a clk rise and given ample settle cycles before sampling.
// Backpressure: not applicable.
module tb_efuse_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk, cs, rw, pgm, err_clr;
  logic        dout, frame_done;
  logic [31:0] fuse_q;
  logic [7:0]  burn_cnt;
  logic [2:0]  err;

  int          checks = 0;
  int          errors = 0;
  int          fd_cnt = 0;
  int          fd0;
  logic [63:0] rd;

  always #20 clk = ~clk;

  efuse_emulator #(
    .NBITS(32), .PGM_MIN_CYC(4), .SYNC_STAGES(2), .INIT_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .EFUSE_SCLK(sclk), .EFUSE_CS(cs), .EFUSE_RW(rw), .EFUSE_PGM(pgm),
    .EFUSE_DOUT(dout), .fuse_q(fuse_q), .frame_done(frame_done),
    .burn_cnt(burn_cnt), .err(err), .err_clr(err_clr)
  );

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cs_start(input logic is_prog);
    rw = is_prog; cyc(4);
    cs = 1'b1;    cyc(6);
  endtask

  task automatic cs_end();
    cs = 1'b0; cyc(6);
  endtask

  task automatic sclk_pulse();
    sclk = 1'b1; cyc(5);
    sclk = 1'b0; cyc(5);
  endtask

  task automatic pgm_pulse(input int width);
    pgm = 1'b1; cyc(width);
    pgm = 1'b0; cyc(6);
  endtask

  task automatic clr_err();
    err_clr = 1'b1; cyc(1);
    err_clr = 1'b0; cyc(1);
  endtask

  task automatic prog_frame(input logic [31:0] val, input int width);
    cs_start(1'b1);
    for (int i = 0; i < 32; i++) begin
      if (val[i]) pgm_pulse(width);
      sclk_pulse();
    end
    cs_end();
  endtask

  // Sample DOUT for the current slot, then advance with one SCLK.
  task automatic read_frame(input int n, output logic [63:0] v);
    v = '0;
    cs_start(1'b0);
    for (int i = 0; i < n; i++) begin
      v[i] = dout;
      sclk_pulse();
    end
    cs_end();
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs = 1'b0; rw = 1'b0; pgm = 1'b0; err_clr = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("rst_dout",     {63'd0, dout},        64'd0);
    chk("rst_fuse",     {32'd0, fuse_q},      64'd0);
    chk("rst_fdone",    {63'd0, frame_done},  64'd0);
    chk("rst_burn_cnt", {56'd0, burn_cnt},    64'd0);
    chk("rst_err",      {61'd0, err},         64'd0);

    // Virgin read, 32 SCLK
    fd0 = fd_cnt;
    read_frame(32, rd);
    chk("virgin_read",  rd,                   64'd0);
    chk("virgin_fdone", 64'(fd_cnt - fd0),    64'd1);
    chk("virgin_err",   {61'd0, err},         64'd0);

    // First program and read-back
    fd0 = fd_cnt;
    prog_frame(32'hA5A5_0F0F, 8);
    chk("prog1_fuse",   {32'd0, fuse_q},      64'hA5A5_0F0F);
    chk("prog1_burn",   {56'd0, burn_cnt},    64'd16);
    chk("prog1_fdone",  64'(fd_cnt - fd0),    64'd1);
    chk("prog1_err",    {61'd0, err},         64'd0);
    read_frame(32, rd);
    chk("read1",        rd,                   64'hA5A5_0F0F);

    // Second program: only new 0->1 bits are counted
    prog_frame(32'h0000_00F0, 8);
    chk("prog2_fuse",   {32'd0, fuse_q},      64'hA5A5_0FFF);
    chk("prog2_burn",   {56'd0, burn_cnt},    64'd20);

    // 34 SCLK read: slots 32/33 read 0, the 33rd rise overruns
    read_frame(34, rd);
    chk("ovr_read",     rd,                   64'h0000_0000_A5A5_0FFF);
    chk("ovr_err",      {61'd0, err},         64'b001);
    clr_err();
    chk("ovr_clr",      {61'd0, err},         64'd0);

    // Reset restores INIT_VAL
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(2);
    chk("rst2_fuse",    {32'd0, fuse_q},      64'd0);
    chk("rst2_burn",    {56'd0, burn_cnt},    64'd0);

    // RW toggled mid-frame: WAIT_CS, PGM ignored, no frame_done
    fd0 = fd_cnt;
    cs_start(1'b1);
    chk("prog_dout0",   {63'd0, dout},        64'd0);
    rw = 1'b0; cyc(6);
    pgm_pulse(8);
    sclk_pulse();
    cs_end();
    chk("rwchg_err",    {61'd0, err},         64'b100);
    chk("rwchg_fdone",  64'(fd_cnt - fd0),    64'd0);
    chk("rwchg_fuse",   {32'd0, fuse_q},      64'd0);
    clr_err();

    // 2-cycle PGM on bit 3: no burn, short-pulse flag
    cs_start(1'b1);
    for (int i = 0; i < 3; i++) sclk_pulse();
    pgm_pulse(2);
    cs_end();
    chk("short_fuse",   {32'd0, fuse_q},      64'd0);
    chk("short_err",    {61'd0, err},         64'b010);
    chk("short_burn",   {56'd0, burn_cnt},    64'd0);
    clr_err();
    chk("short_clr",    {61'd0, err},         64'd0);

    // CS falls while PGM is still high: pulse discarded
    fd0 = fd_cnt;
    cs_start(1'b1);
    pgm = 1'b1; cyc(8);
    cs = 1'b0;  cyc(6);
    pgm = 1'b0; cyc(6);
    chk("csdrop_fuse",  {32'd0, fuse_q},      64'd0);
    chk("csdrop_err",   {61'd0, err},         64'b010);
    chk("csdrop_fdone", 64'(fd_cnt - fd0),    64'd1);
    clr_err();

    // Burn the top bit, then try bit 0 in a later frame
    prog_frame(32'h8000_0000, 8);
    chk("lock_set",     {32'd0, fuse_q},      64'h8000_0000);
    prog_frame(32'h0000_0001, 8);
`ifdef EFUSE_EMU_LOCK_EN
    chk("lock_fuse",    {32'd0, fuse_q},      64'h8000_0000);
    chk("lock_err",     {61'd0, err},         64'b010);
    chk("lock_burn",    {56'd0, burn_cnt},    64'd1);
`else
    chk("nolock_fuse",  {32'd0, fuse_q},      64'h8000_0001);
    chk("nolock_err",   {61'd0, err},         64'd0);
    chk("nolock_burn",  {56'd0, burn_cnt},    64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
